conv_3x3_weight_streamer: RTL and testbench
===========================================

# conv_3x3_weight_streamer

Weight-side transmitter for the 3x3 dilated convolution tops. It reads kernel coefficients from a fixed-latency weight memory and emits them as the `valid_weight_in`/`weight_in` stream the conv top consumes. Weights are emitted in strict order: output channel, then input channel, then tap. Emission is paced by a group-granular ready from the consumer. One instance sits beside each conv top, between the weight BRAM/ROM and the conv's weight port.

## Interface
- DATA_WIDTH, 32, weight word width
- CHANNEL_NUM_IN, 1024, input channels per filter
- CHANNEL_NUM_OUT, 1024, filters
- KERNEL, 3, kernel width; a group is KERNEL*KERNEL taps
- ADDR_WIDTH, 24, weight memory address width; must hold CHANNEL_NUM_IN*CHANNEL_NUM_OUT*KERNEL*KERNEL
- MEM_LATENCY, 2, cycles from mem_rd_en to mem_rd_data valid (1..4)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a full weight pass
- weight_ready  in  1  consumer can accept one more group of KERNEL*KERNEL weights
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_rd_data  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_rd_en
- weight_out  out  DATA_WIDTH  weight word (to conv weight_in)
- valid_weight_out  out  1  weight_out valid (to conv valid_weight_in)
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

## Operation
- States: IDLE, GROUP_WAIT, FETCH, DRAIN.
- IDLE:
  - start=1 clears the address, tap, ci and co counters; next state is GROUP_WAIT; busy=1.
  - start while not in IDLE is ignored.
- GROUP_WAIT:
  - weight_ready=1 moves to FETCH; otherwise stay.
  - weight_ready is sampled only here.
- FETCH:
  - mem_rd_en=1 every cycle; mem_addr = address counter; address increments every cycle.
  - tap counts 0..K*K-1. When tap wraps, ci increments; when ci wraps at CHANNEL_NUM_IN, co increments.
  - A group is never interrupted; weight_ready changes mid-group have no effect.
  - At end of group: last group (co=COUT-1, ci=CIN-1) goes to DRAIN; otherwise GROUP_WAIT.
- DRAIN:
  - No reads are issued. Wait until the read-valid shift register is empty.
  - Then: done=1 for one cycle, busy=0, return to IDLE.
- Data path:
  - A MEM_LATENCY-deep valid shift register is fed by mem_rd_en.
  - When its tail is 1, register weight_out <= mem_rd_data and set valid_weight_out=1.
- Linear address = ((co*CIN)+ci)*K*K + tap. This is implemented as a plain incrementer, with no multipliers.
- Reset (any time, including mid-pass):
  - mem_rd_en=0, mem_addr=0, weight_out=0, valid_weight_out=0, busy=0, done=0.
  - All counters and the shift register are cleared; state is IDLE.
  - In-flight reads are discarded.

## Timing
- start sampled in cycle 0 → GROUP_WAIT in cycle 1.
- If weight_ready=1 in cycle 1, the first mem_rd_en is in cycle 2.
- First valid_weight_out is in cycle 2+MEM_LATENCY+1 (one cycle of output register).
- Back-to-back groups with weight_ready held high have one idle cycle between groups (GROUP_WAIT).
- done pulses the cycle after the final valid_weight_out.
- Gaps in valid_weight_out occur only at group boundaries.

## Configuration
- `CONV_WEIGHT_GROUP_CNT_EN` defined:
  - Adds output port group_cnt, width clog2(CIN*COUT+1).
  - Resets to 0, clears on accepted start, increments when a group's last weight is emitted.
  - Holds its final value after done.
- Undefined: no port and no counter logic.

## Structure
- Shared package `conv_weight_pkg`:
  - FSM state typedef.
  - Localparams TAPS = KERNEL*KERNEL and TOTAL_WEIGHTS.
  - Counter-width helper.
- One natural sub-module: `conv_valid_delay_line`, a parameterized MEM_LATENCY valid shift register with async active-low clear.

## Test plan
- Use CIN=2, COUT=2, MEM_LATENCY=2 with weight_ready held high. Memory returns data = addr. Start → 36 valid weights with values 0..35 in order, 4 groups, one-cycle gap between groups, then a single done pulse.
- Toggle weight_ready low for 5 cycles after group 1. Stream pauses only after group 1's 9 taps complete and resumes on ready; the value sequence is unchanged.
- Drop weight_ready in the middle of a group. The group still completes all 9 reads without a gap.
- Issue start pulses while busy. Ignored: no counter reset, still 36 outputs, a single done.
- Assert reset at output index 17, then issue a new start. Outputs are 0 during reset; no stale valid appears; the new pass restarts at addr 0 and emits 0..35.
- With `CONV_WEIGHT_GROUP_CNT_EN` defined: group_cnt steps 0→4, reads 4 at done, and clears to 0 on the next start.

Source files
------------

// File: rtl/conv_weight_pkg.sv
// Shared types and sizing helpers for the conv weight streamer slice.
// Default-geometry constants here; each instance derives its own from its parameters.
package conv_weight_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GROUP_WAIT,
    ST_FETCH,
    ST_DRAIN
  } state_t;

  localparam int KERNEL_DEF    = 3;
  localparam int CIN_DEF       = 1024;
  localparam int COUT_DEF      = 1024;
  localparam int TAPS          = KERNEL_DEF * KERNEL_DEF;
  localparam int TOTAL_WEIGHTS = CIN_DEF * COUT_DEF * TAPS;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_valid_delay_line.sv
// Read-valid shift register matching the weight memory latency.
// o_empty tells the streamer that no read is still in flight.
module conv_valid_delay_line
  import conv_weight_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_vld,
  output logic o_vld,
  output logic o_empty
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_vld;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_vld   = r_sr[DEPTH-1];
  assign o_empty = ~|r_sr;

endmodule

// File: rtl/conv_3x3_weight_streamer.sv
// Streams conv weights from a fixed-latency memory in co/ci/tap order, one group per ready.
// Optional CONV_WEIGHT_GROUP_CNT_EN adds a group_cnt output of emitted groups.
module conv_3x3_weight_streamer
  import conv_weight_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNEL_NUM_IN  = 1024,
  parameter int CHANNEL_NUM_OUT = 1024,
  parameter int KERNEL          = 3,
  parameter int ADDR_WIDTH      = 24,
  parameter int MEM_LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  weight_ready,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_weight_out,
  output logic                  busy,
  output logic                  done
`ifdef CONV_WEIGHT_GROUP_CNT_EN
  ,output logic [$clog2(CHANNEL_NUM_IN*CHANNEL_NUM_OUT+1)-1:0] group_cnt
`endif
);

  localparam int TAPS_N = KERNEL * KERNEL;
  localparam int TAP_W  = cnt_w(TAPS_N);
  localparam int CI_W   = cnt_w(CHANNEL_NUM_IN);
  localparam int CO_W   = cnt_w(CHANNEL_NUM_OUT);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS_N - 1);
  localparam logic [CI_W-1:0]  CI_LAST  = CI_W'(CHANNEL_NUM_IN - 1);
  localparam logic [CO_W-1:0]  CO_LAST  = CO_W'(CHANNEL_NUM_OUT - 1);

  state_t                  r_state;
  logic [TAP_W-1:0]        r_tap;
  logic [CI_W-1:0]         r_ci;
  logic [CO_W-1:0]         r_co;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_rd_en;
  logic                    r_busy;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_wout;
  logic                    r_vld;
  logic                    w_rd_tail;
  logic                    w_rd_empty;
  logic                    w_tap_last;
  logic                    w_ci_last;
  logic                    w_co_last;

  assign w_tap_last = (r_tap == TAP_LAST);
  assign w_ci_last  = (r_ci == CI_LAST);
  assign w_co_last  = (r_co == CO_LAST);

  // The address counter advances in lockstep with tap/ci/co, so it always equals
  // the linear co/ci/tap index without any multiply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tap   <= '0;
      r_ci    <= '0;
      r_co    <= '0;
      r_addr  <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tap   <= '0;
            r_ci    <= '0;
            r_co    <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_GROUP_WAIT;
          end
        end
        ST_GROUP_WAIT: begin
          if (weight_ready) begin
            r_rd_en <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_addr <= r_addr + 1'b1;
          if (w_tap_last) begin
            r_tap   <= '0;
            r_rd_en <= 1'b0;
            r_state <= (w_ci_last && w_co_last) ? ST_DRAIN : ST_GROUP_WAIT;
            if (w_ci_last) begin
              r_ci <= '0;
              r_co <= r_co + 1'b1;
            end else begin
              r_ci <= r_ci + 1'b1;
            end
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_rd_empty) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  conv_valid_delay_line #(
    .DEPTH (MEM_LATENCY)
  ) u_vld_dly (
    .clk     (clk),
    .i_rst_n (reset),
    .i_vld   (r_rd_en),
    .o_vld   (w_rd_tail),
    .o_empty (w_rd_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wout <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= w_rd_tail;
      if (w_rd_tail) r_wout <= mem_rd_data;
    end
  end

`ifdef CONV_WEIGHT_GROUP_CNT_EN
  logic [TAP_W-1:0] r_otap;
  logic [$clog2(CHANNEL_NUM_IN*CHANNEL_NUM_OUT+1)-1:0] r_gcnt;

  // Counts words leaving the output register; a wrap marks a completed group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_otap <= '0;
      r_gcnt <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_otap <= '0;
      r_gcnt <= '0;
    end else if (w_rd_tail) begin
      if (r_otap == TAP_LAST) begin
        r_otap <= '0;
        r_gcnt <= r_gcnt + 1'b1;
      end else begin
        r_otap <= r_otap + 1'b1;
      end
    end
  end

  assign group_cnt = r_gcnt;
`endif

  assign mem_rd_en        = r_rd_en;
  assign mem_addr         = r_addr;
  assign weight_out       = r_wout;
  assign valid_weight_out = r_vld;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule

// File: tb/tb_conv_3x3_weight_streamer.sv
// Randomized bench for conv_3x3_weight_streamer against an ordered-sequence reference model.
module tb_conv_3x3_weight_streamer;

  localparam int DW   = 32;
  localparam int CIN  = 2;
  localparam int COUT = 2;
  localparam int K    = 3;
  localparam int AW   = 24;
  localparam int LAT  = 2;
  localparam int TAPS = K * K;
  localparam int NG   = CIN * COUT;
  localparam int NW   = NG * TAPS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          weight_ready;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] weight_out;
  logic          valid_weight_out;
  logic          busy;
  logic          done;
`ifdef CONV_WEIGHT_GROUP_CNT_EN
  logic [$clog2(NG+1)-1:0] group_cnt;
`endif

  always #5 clk = ~clk;

  conv_3x3_weight_streamer #(
    .DATA_WIDTH      (DW),
    .CHANNEL_NUM_IN  (CIN),
    .CHANNEL_NUM_OUT (COUT),
    .KERNEL          (K),
    .ADDR_WIDTH      (AW),
    .MEM_LATENCY     (LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .weight_ready     (weight_ready),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_rd_data      (mem_rd_data),
    .weight_out       (weight_out),
    .valid_weight_out (valid_weight_out),
    .busy             (busy),
    .done             (done)
`ifdef CONV_WEIGHT_GROUP_CNT_EN
    ,.group_cnt       (group_cnt)
`endif
  );

  // Memory model: word at address a holds a ^ salt, returned LAT cycles after the read.
  logic [DW-1:0] salt = '0;
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= DW'(mem_addr) ^ salt;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rd_data = pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference observations for the current pass.
  bit   mon_en = 1'b0;
  int   n_out, n_rd, run_len, done_cnt, last_vld_cyc, first_vld_cyc, s_cyc;
  int   grp_start [NG];
  logic prev_ready = 1'b0;
  logic prev_rd    = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_weight_out) begin
        if (n_out < NW) chk("wval", weight_out, DW'(n_out) ^ salt);
        else            chk("n_out_bound", n_out, NW - 1);
        if (n_out % TAPS == 0) begin
          if (n_out / TAPS < NG) grp_start[n_out / TAPS] = cyc;
          if (n_out == 0) first_vld_cyc = cyc;
        end else begin
          chk("in_grp_gap", cyc - last_vld_cyc, 1);
        end
`ifdef CONV_WEIGHT_GROUP_CNT_EN
        chk("gcnt_step", group_cnt,
            ((n_out + 1) % TAPS == 0) ? (n_out + 1) / TAPS : n_out / TAPS);
`endif
        last_vld_cyc = cyc;
        n_out++;
      end
      if (mem_rd_en) begin
        chk("addr", mem_addr, n_rd);
        if (!prev_rd) begin
          chk("rdy_before_grp", prev_ready, 1);
          run_len = 0;
        end
        run_len++;
        n_rd++;
      end else if (prev_rd) begin
        chk("run_len", run_len, TAPS);
      end
      if (done) begin
        chk("done_lat", cyc - last_vld_cyc, 1);
        chk("done_all_out", n_out, NW);
        done_cnt++;
      end
    end
    prev_ready = weight_ready;
    prev_rd    = mem_rd_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    n_out = 0; n_rd = 0; run_len = 0; done_cnt = 0;
    last_vld_cyc = 0; first_vld_cyc = -1;
    for (int g = 0; g < NG; g++) grp_start[g] = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_wout"},  weight_out, 0);
    chk({tag, "_vld"},   valid_weight_out, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
  endtask

  // mode 0: ready high; 1: scripted ready drops; 2: random ready; 3: spurious starts while busy
  task automatic run_pass(input int mode, input int budget);
    int drop;
    bit f1, f2;
    drop = 0; f1 = 0; f2 = 0;
    salt = $urandom;
    mon_clear();
    weight_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
`ifdef CONV_WEIGHT_GROUP_CNT_EN
    chk("gcnt_clear", group_cnt, 0);
`endif
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      case (mode)
        1: begin
          if (!f1 && n_rd == TAPS)     begin f1 = 1; drop = 5; end
          if (!f2 && n_rd == 2*TAPS+3) begin f2 = 1; drop = 3; end
          if (drop > 0) begin weight_ready = 1'b0; drop--; end
          else weight_ready = 1'b1;
        end
        2: weight_ready = 1'($urandom_range(0, 1));
        3: start = busy && ($urandom_range(0, 3) == 0);
        default: weight_ready = 1'b1;
      endcase
      tick();
    end
    start = 1'b0;
    weight_ready = 1'b1;
    repeat (6) tick();
    chk("done_cnt", done_cnt, 1);
    chk("n_out", n_out, NW);
    chk("busy_end", busy, 0);
`ifdef CONV_WEIGHT_GROUP_CNT_EN
    chk("gcnt_final", group_cnt, NG);
`endif
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    weight_ready = 1'b0;
    repeat (3) tick();
    check_outputs_zero("rst");
    reset = 1'b1;
    repeat (2) tick();
    mon_en = 1'b1;

    run_pass(0, 400);
    chk("first_lat", first_vld_cyc - s_cyc, 2 + LAT + 1);
    for (int g = 1; g < NG; g++) chk("grp_spacing", grp_start[g] - grp_start[g-1], TAPS + 1);

    run_pass(1, 400);
    chk("pause_spacing", grp_start[1] - grp_start[0], TAPS + 1 + 5);
    chk("midgrp_spacing", grp_start[3] - grp_start[2], TAPS + 1);

    for (int r = 0; r < 3; r++) run_pass(2, 1000);
    run_pass(3, 400);

    // Reset in the middle of a pass, then a clean restart.
    salt = $urandom;
    mon_clear();
    weight_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && n_out < 17; i++) tick();
    chk("reach_idx17", n_out, 17);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (3) begin
      tick();
      chk("rst_hold_vld", valid_weight_out, 0);
    end
    reset = 1'b1;
    repeat (5) begin
      tick();
      chk("stale_vld", valid_weight_out, 0);
      chk("stale_rd", mem_rd_en, 0);
    end
    mon_en = 1'b1;
    run_pass(0, 400);
    chk("restart_lat", first_vld_cyc - s_cyc, 2 + LAT + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
